// File: rtl/adder_acc_pkg.sv
// +-----------------------------------------------------------------------------+
// | adder_acc_pkg                                                               |
// | Shared types and default sizes for the adder accumulator and its bench.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package adder_acc_pkg;

    localparam int ACC_WIDTH   = 4;
    localparam int ACC_MAX_LEN = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCUM  = 2'b01,
        RESULT = 2'b10
    } acc_state_t;

    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder.sv
// +-----------------------------------------------------------------------------+
// | adder                                                                       |
// | WIDTH-bit ripple-carry adder with carry-in and carry-out.                   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
            assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/adder_accumulator.sv
// +-----------------------------------------------------------------------------+
// | adder_accumulator                                                           |
// | Sums a stream of len operands through the ripple adder; one result per job. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module adder_accumulator
    import adder_acc_pkg::*;
#(
    parameter  int WIDTH   = ACC_WIDTH,
    parameter  int MAX_LEN = ACC_MAX_LEN,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    acc_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_remaining;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (r_acc),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // A zero-length job skips ACCUM and reports an empty, overflow-free result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                        if (len != '0) begin
                            r_remaining <= len;
                            r_state     <= ACCUM;
                        end else begin
                            r_state     <= RESULT;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        r_acc       <= w_sum;
                        r_ovf       <= r_ovf | w_cout;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == RESULT);
    assign busy      = (r_state == ACCUM) || (r_state == RESULT);
    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_accumulator.sv
// +-----------------------------------------------------------------------------+
// | tb_adder_accumulator                                                        |
// | Self-checking bench: directed scenarios plus randomized jobs vs. a model.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_adder_accumulator;
    import adder_acc_pkg::*;

    localparam int W  = ACC_WIDTH;
    localparam int CW = $clog2(ACC_MAX_LEN + 1);

    typedef logic [W-1:0] ops_t [16];

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [CW-1:0] len       = '0;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_sum;
    logic          out_ovf;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    adder_accumulator u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: integer running total, wrapped whenever it reaches 2^W.
    function automatic void model(input int n, input ops_t ops,
                                  output logic [W-1:0] s, output logic o);
        int total;
        total = 0;
        o     = 1'b0;
        for (int i = 0; i < n; i++) begin
            total = total + int'(ops[i]);
            if (total >= (1 << W)) begin
                o     = 1'b1;
                total = total - (1 << W);
            end
        end
        s = total[W-1:0];
    endfunction

    // bubbles: 0 none, 1 idle cycle before every operand but the first, 2 random
    task automatic run_job(input int n, input ops_t ops, input int bubbles,
                           output logic lat_ok, output logic got_result);
        @(negedge clk);
        start = 1'b1;
        len   = CW'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ((bubbles == 1 && i > 0) || (bubbles == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = ops[i];
            @(negedge clk);
        end
        in_valid   = 1'b0;
        lat_ok     = out_valid;
        got_result = out_valid;
        for (int k = 0; k < 50 && got_result !== 1'b1; k++) begin
            @(negedge clk);
            got_result = out_valid;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        len   = CW'(3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++;
            if ({out_valid, in_ready, busy, out_sum, out_ovf} !== '0)
                $display("FAIL reset_outputs cycle %0d: got v=%b r=%b b=%b s=%0d o=%b want all 0",
                         c, out_valid, in_ready, busy, out_sum, out_ovf);
            else n_pass++;
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd3;
        run_job(3, ops, 0, lat_ok, got);
        n_total++;
        if (lat_ok !== 1'b1) $display("FAIL basic_latency: out_valid=%b one cycle after last operand, want 1", lat_ok);
        else n_pass++;
        n_total++;
        if (out_sum !== 4'd6 || out_ovf !== 1'b0)
            $display("FAIL basic_result: got sum=%0d ovf=%b want sum=6 ovf=0", out_sum, out_ovf);
        else n_pass++;
        release_result();
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_handoff: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        ops[0] = 4'd9; ops[1] = 4'd8;
        run_job(2, ops, 0, lat_ok, got);
        n_total++;
        if (got !== 1'b1 || out_sum !== 4'd1 || out_ovf !== 1'b1)
            $display("FAIL wrap_9_8: got valid=%b sum=%0d ovf=%b want 1 1 1", got, out_sum, out_ovf);
        else n_pass++;
        release_result();
        ops = '{default: '0};
        ops[0] = 4'd15; ops[1] = 4'd1; ops[2] = 4'd0;
        run_job(3, ops, 0, lat_ok, got);
        n_total++;
        if (got !== 1'b1 || out_sum !== 4'd0 || out_ovf !== 1'b1)
            $display("FAIL wrap_sticky: got valid=%b sum=%0d ovf=%b want 1 0 1", got, out_sum, out_ovf);
        else n_pass++;
        release_result();
    endtask

    task automatic test_bubbles();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        for (int i = 0; i < 4; i++) ops[i] = 4'd2;
        run_job(4, ops, 1, lat_ok, got);
        n_total++;
        if (got !== 1'b1 || out_sum !== 4'd8 || out_ovf !== 1'b0)
            $display("FAIL bubbles: got valid=%b sum=%0d ovf=%b want 1 8 0", got, out_sum, out_ovf);
        else n_pass++;
        release_result();
    endtask

    task automatic test_backpressure();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        ops[0] = 4'd5; ops[1] = 4'd6;
        run_job(2, ops, 0, lat_ok, got);
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            len   = CW'(1);
            @(negedge clk);
            n_total++;
            if ({out_valid, busy, out_sum, out_ovf} !== {1'b1, 1'b1, 4'd11, 1'b0})
                $display("FAIL backpressure_hold cycle %0d: got v=%b b=%b s=%0d o=%b want 1 1 11 0",
                         c, out_valid, busy, out_sum, out_ovf);
            else n_pass++;
        end
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL handoff_start_ignored: got busy=%b out_valid=%b want 0 0", busy, out_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL handoff_stays_idle: busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_empty();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        run_job(0, ops, 0, lat_ok, got);
        n_total++;
        if (lat_ok !== 1'b1 || out_sum !== 4'd0 || out_ovf !== 1'b0)
            $display("FAIL empty_job: got valid=%b sum=%0d ovf=%b want 1 0 0", lat_ok, out_sum, out_ovf);
        else n_pass++;
        release_result();
    endtask

    task automatic test_reset_mid_job();
        ops_t ops = '{default: '0};
        logic lat_ok, got;
        @(negedge clk);
        start = 1'b1;
        len   = CW'(3);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid, in_ready, busy, out_sum, out_ovf} !== '0)
            $display("FAIL reset_mid_job_async: got v=%b r=%b b=%b s=%0d o=%b want all 0",
                     out_valid, in_ready, busy, out_sum, out_ovf);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid_job_idle: got out_valid=%b busy=%b want 0 0", out_valid, busy);
        else n_pass++;
        ops[0] = 4'd1; ops[1] = 4'd1;
        run_job(2, ops, 0, lat_ok, got);
        n_total++;
        if (got !== 1'b1 || out_sum !== 4'd2 || out_ovf !== 1'b0)
            $display("FAIL reset_mid_job_next: got valid=%b sum=%0d ovf=%b want 1 2 0", got, out_sum, out_ovf);
        else n_pass++;
        release_result();
    endtask

    task automatic test_random();
        ops_t ops;
        logic lat_ok, got;
        logic [W-1:0] exp_s;
        logic exp_o;
        int n;
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(0, ACC_MAX_LEN);
            for (int i = 0; i < 16; i++) ops[i] = W'($urandom_range(0, (1 << W) - 1));
            model(n, ops, exp_s, exp_o);
            run_job(n, ops, 2, lat_ok, got);
            n_total++;
            if (got !== 1'b1 || out_sum !== exp_s || out_ovf !== exp_o)
                $display("FAIL random_job %0d len=%0d: got valid=%b sum=%0d ovf=%b want 1 %0d %b",
                         j, n, got, out_sum, out_ovf, exp_s, exp_o);
            else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bubbles();
        test_backpressure();
        test_empty();
        test_reset_mid_job();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
